// File: rtl/ppu_pixel_fifo_mixer_if.sv
// Bundle between the tile/sprite fetchers, the pixel FIFO/mixer and the LCD writer.
// The master side is the fetch/control logic; the slave side is ppu_pixel_fifo_mixer.
interface ppu_pixel_fifo_mixer_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
);
  logic             line_start;
  logic [2:0]       discard_n;
  logic             bg_en;
  logic [7:0]       bg_lo;
  logic [7:0]       bg_hi;
  logic             bg_push;
  logic             bg_ready;
  logic [CNT_W-1:0] bg_count;
  logic [7:0]       sp_lo;
  logic [7:0]       sp_hi;
  logic [7:0]       sp_attr;
  logic             sp_push;
  logic             px_stall;
  logic [7:0]       bgp;
  logic [7:0]       obp0;
  logic [7:0]       obp1;
  logic [1:0]       px_out;
  logic             px_valid;
  logic             overflow;

  modport master (
    output line_start, discard_n, bg_en, bg_lo, bg_hi, bg_push,
    output sp_lo, sp_hi, sp_attr, sp_push, px_stall, bgp, obp0, obp1,
    input  bg_ready, bg_count, px_out, px_valid, overflow
  );

  modport slave (
    input  line_start, discard_n, bg_en, bg_lo, bg_hi, bg_push,
    input  sp_lo, sp_hi, sp_attr, sp_push, px_stall, bgp, obp0, obp1,
    output bg_ready, bg_count, px_out, px_valid, overflow
  );
endinterface

// File: rtl/ppu_pixel_fifo_mixer.sv
// BG pixel FIFO, 8-slot sprite overlay and BG/OBJ mixer for the PPU draw path.
// One pixel is popped per unstalled cycle and its palette shade is registered out.
module ppu_pixel_fifo_mixer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input logic                   clk,
  input logic                   rst,
  ppu_pixel_fifo_mixer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] col;
    logic       pal;
    logic       prio;
  } ov_slot_t;

  logic [1:0]       fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ov_slot_t         ov_q [8];
  ov_slot_t         ov_d [8];
  ov_slot_t         ov_shift [8];
  logic [2:0]       discard_q, discard_d;
  logic [1:0]       px_out_q, px_out_d;
  logic             px_valid_q, px_valid_d;
  logic             overflow_q, overflow_d;

  logic       bg_ready;
  logic       pop;
  logic       push;
  logic [1:0] bg_pix;
  logic [1:0] mix;
  logic [1:0] new_col;
  logic [7:0] obp_sel;
  ov_slot_t   slot0;

  // Readiness is judged on the registered count, before this cycle's pop.
  assign bg_ready = count_q <= CNT_W'(DEPTH - 8);

  assign bus.bg_ready = bg_ready;
  assign bus.bg_count = count_q;
  assign bus.px_out   = px_out_q;
  assign bus.px_valid = px_valid_q;
  assign bus.overflow = overflow_q;

  always_comb begin
    pop    = !bus.line_start && !bus.px_stall && (count_q != '0);
    push   = !bus.line_start && bus.bg_push && bg_ready;
    bg_pix = bus.bg_en ? fifo_q[rd_ptr_q] : 2'd0;
    slot0  = ov_q[0];

    obp_sel = slot0.pal ? bus.obp1 : bus.obp0;
    if (slot0.col != 2'd0 && !(slot0.prio && bg_pix != 2'd0)) begin
      mix = obp_sel[{slot0.col, 1'b0} +: 2];
    end else begin
      mix = bus.bgp[{bg_pix, 1'b0} +: 2];
    end

    // Overlay advances with every pop so slot 0 stays aligned with the next BG pixel.
    for (int i = 0; i < 7; i++) begin
      ov_shift[i] = pop ? ov_q[i+1] : ov_q[i];
    end
    ov_shift[7] = pop ? '0 : ov_q[7];

    new_col = 2'd0;
    for (int i = 0; i < 8; i++) begin
      new_col  = {bus.sp_hi[3'(7 - i)], bus.sp_lo[3'(7 - i)]};
      ov_d[i]  = ov_shift[i];
      if (bus.sp_push && ov_shift[i].col == 2'd0 && new_col != 2'd0) begin
        ov_d[i] = '{col: new_col, pal: bus.sp_attr[4], prio: bus.sp_attr[7]};
      end
      if (bus.line_start) begin
        ov_d[i] = '0;
      end
    end

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      count_d  = count_d + CNT_W'(8);
      wr_ptr_d = wr_ptr_q + AW'(8);
    end
    if (pop) begin
      count_d  = count_d - CNT_W'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    px_valid_d = 1'b0;
    px_out_d   = px_out_q;
    discard_d  = discard_q;
    if (pop) begin
      if (discard_q != 3'd0) begin
        discard_d = discard_q - 3'd1;
      end else begin
        px_valid_d = 1'b1;
        px_out_d   = mix;
      end
    end

    if (bus.line_start) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      discard_d = bus.discard_n;
    end

    overflow_d = overflow_q | (!bus.line_start && bus.bg_push && !bg_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      discard_q  <= 3'd0;
      px_out_q   <= 2'd0;
      px_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        ov_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      px_out_q   <= px_out_d;
      px_valid_q <= px_valid_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < 8; i++) begin
        ov_q[i] <= ov_d[i];
      end
    end
  end

  // Pixel storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        fifo_q[wr_ptr_q + AW'(i)] <= {bus.bg_hi[3'(7 - i)], bus.bg_lo[3'(7 - i)]};
      end
    end
  end
endmodule

// File: tb/tb_ppu_pixel_fifo_mixer.sv
// Directed bench for ppu_pixel_fifo_mixer: FIFO order, discard, sprite merge, priority,
// palettes, overflow and line_start behaviour, each with hand-computed expected shades.
module tb_ppu_pixel_fifo_mixer;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ppu_pixel_fifo_mixer_if #(.DEPTH(DEPTH)) bus ();

  ppu_pixel_fifo_mixer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.line_start = 1'b0;
    bus.discard_n  = 3'd0;
    bus.bg_en      = 1'b1;
    bus.bg_lo      = 8'h00;
    bus.bg_hi      = 8'h00;
    bus.bg_push    = 1'b0;
    bus.sp_lo      = 8'h00;
    bus.sp_hi      = 8'h00;
    bus.sp_attr    = 8'h00;
    bus.sp_push    = 1'b0;
    bus.px_stall   = 1'b1;
    bus.bgp        = 8'hE4;
    bus.obp0       = 8'hE4;
    bus.obp1       = 8'h00;
  endtask

  task automatic start_line(input logic [2:0] d);
    bus.line_start = 1'b1;
    bus.discard_n  = d;
    tick();
    bus.line_start = 1'b0;
    bus.discard_n  = 3'd0;
  endtask

  task automatic push_bg(input logic [7:0] lo, input logic [7:0] hi);
    bus.bg_lo   = lo;
    bus.bg_hi   = hi;
    bus.bg_push = 1'b1;
    tick();
    bus.bg_push = 1'b0;
  endtask

  task automatic push_sp(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr);
    bus.sp_lo   = lo;
    bus.sp_hi   = hi;
    bus.sp_attr = attr;
    bus.sp_push = 1'b1;
    tick();
    bus.sp_push = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    if (bus.px_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_px_valid got %0d want 0", bus.px_valid);
    end
    vectors++;
    if (bus.px_out !== 2'd0) begin
      miscompares++; $display("FAIL reset_px_out got %0d want 0", bus.px_out);
    end
    vectors++;
    if (bus.bg_count !== 5'd0) begin
      miscompares++; $display("FAIL reset_count got %0d want 0", bus.bg_count);
    end
    vectors++;
    if (bus.bg_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got %0d want 1", bus.bg_ready);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_overflow got %0d want 0", bus.overflow);
    end
    vectors++;
    rst = 1'b0;
    bus.px_stall = 1'b0;
    tick();
    if (bus.px_valid !== 1'b0) begin
      miscompares++; $display("FAIL empty_pop_valid got %0d want 0", bus.px_valid);
    end
    vectors++;
    bus.px_stall = 1'b1;
  endtask

  task automatic test_basic_pop();
    start_line(3'd0);
    push_bg(8'hFF, 8'h00);
    if (bus.bg_count !== 5'd8 || bus.px_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_after_push count=%0d valid=%0d want 8/0", bus.bg_count, bus.px_valid);
    end
    vectors++;
    bus.px_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.px_valid !== 1'b1 || bus.px_out !== 2'd1) begin
        miscompares++;
        $display("FAIL t1_px[%0d] valid=%0d out=%0d want 1/1", i, bus.px_valid, bus.px_out);
      end
      vectors++;
    end
    tick();
    if (bus.px_valid !== 1'b0 || bus.bg_count !== 5'd0) begin
      miscompares++;
      $display("FAIL t1_drained valid=%0d count=%0d want 0/0", bus.px_valid, bus.bg_count);
    end
    vectors++;
    bus.px_stall = 1'b1;
  endtask

  task automatic test_discard();
    logic [1:0] exp [8];
    // AA/CC gives indices 3,2,1,0,3,2,1,0; the first three are dropped.
    exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    start_line(3'd3);
    push_bg(8'hAA, 8'hCC);
    bus.px_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 3) begin
        if (bus.px_valid !== 1'b0) begin
          miscompares++; $display("FAIL t2_discard[%0d] valid got %0d want 0", i, bus.px_valid);
        end
      end else if (bus.px_valid !== 1'b1 || bus.px_out !== exp[i]) begin
        miscompares++;
        $display("FAIL t2_px[%0d] valid=%0d out=%0d want 1/%0d", i, bus.px_valid, bus.px_out,
                 exp[i]);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
  endtask

  task automatic test_sprite_overlay();
    logic [1:0] want;
    bus.obp1 = 8'h0C;
    start_line(3'd0);
    push_bg(8'h00, 8'hFF);
    push_bg(8'h00, 8'hFF);
    push_sp(8'hF0, 8'h00, 8'h10);
    bus.px_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      want = (i < 4) ? 2'd3 : 2'd2;
      if (bus.px_valid !== 1'b1 || bus.px_out !== want) begin
        miscompares++;
        $display("FAIL t3_px[%0d] valid=%0d out=%0d want 1/%0d", i, bus.px_valid, bus.px_out,
                 want);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
    bus.obp1 = 8'h00;
  endtask

  task automatic test_obj_priority();
    start_line(3'd0);
    push_bg(8'h00, 8'hFF);
    push_bg(8'h00, 8'h00);
    push_sp(8'hFF, 8'hFF, 8'h80);
    bus.px_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.px_out !== 2'd2) begin
        miscompares++; $display("FAIL t4_bg_over[%0d] got %0d want 2", i, bus.px_out);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
    push_sp(8'hFF, 8'hFF, 8'h80);
    bus.px_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.px_out !== 2'd3) begin
        miscompares++; $display("FAIL t4_obj_shows[%0d] got %0d want 3", i, bus.px_out);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
  endtask

  task automatic test_oam_order();
    logic [1:0] want;
    bus.obp1 = 8'h80;
    start_line(3'd0);
    push_bg(8'h00, 8'h00);
    push_sp(8'hF0, 8'h00, 8'h00);
    push_sp(8'hFF, 8'hFF, 8'h10);
    bus.px_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      want = (i < 4) ? 2'd1 : 2'd2;
      if (bus.px_out !== want) begin
        miscompares++; $display("FAIL t5_oam[%0d] got %0d want %0d", i, bus.px_out, want);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
    bus.obp1 = 8'h00;
  endtask

  task automatic test_merge_with_pop();
    logic [1:0] exp [3];
    exp = '{2'd0, 2'd1, 2'd0};
    start_line(3'd0);
    push_bg(8'h00, 8'h00);
    bus.sp_lo    = 8'h80;
    bus.sp_hi    = 8'h00;
    bus.sp_attr  = 8'h00;
    bus.sp_push  = 1'b1;
    bus.px_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.sp_push = 1'b0;
      if (bus.px_valid !== 1'b1 || bus.px_out !== exp[i]) begin
        miscompares++;
        $display("FAIL merge_pop[%0d] valid=%0d out=%0d want 1/%0d", i, bus.px_valid,
                 bus.px_out, exp[i]);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
  endtask

  task automatic test_bg_disable();
    bus.bgp   = 8'h1B;
    bus.bg_en = 1'b0;
    start_line(3'd0);
    push_bg(8'hFF, 8'hFF);
    bus.px_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.px_out !== 2'd3) begin
        miscompares++; $display("FAIL bg_off[%0d] got %0d want 3", i, bus.px_out);
      end
      vectors++;
    end
    bus.bg_en = 1'b1;
    tick();
    if (bus.px_out !== 2'd0) begin
      miscompares++; $display("FAIL bg_on got %0d want 0", bus.px_out);
    end
    vectors++;
    bus.px_stall = 1'b1;
    bus.bgp = 8'hE4;
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    start_line(3'd0);
    push_bg(8'hFF, 8'h00);
    if (bus.bg_ready !== 1'b1) begin
      miscompares++; $display("FAIL t6_ready8 got %0d want 1", bus.bg_ready);
    end
    vectors++;
    push_bg(8'h00, 8'hFF);
    if (bus.bg_count !== 5'd16 || bus.bg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_full count=%0d ready=%0d want 16/0", bus.bg_count, bus.bg_ready);
    end
    vectors++;
    push_bg(8'hFF, 8'hFF);
    if (bus.bg_count !== 5'd16 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL t6_drop count=%0d ovf=%0d want 16/1", bus.bg_count, bus.overflow);
    end
    vectors++;
    bus.px_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.px_out !== 2'd1) begin
        miscompares++; $display("FAIL t6_first[%0d] got %0d want 1", i, bus.px_out);
      end
      vectors++;
    end
    push_bg(8'hFF, 8'hFF);
    if (bus.bg_count !== 5'd15 || bus.px_out !== 2'd2) begin
      miscompares++;
      $display("FAIL t6_push_pop count=%0d out=%0d want 15/2", bus.bg_count, bus.px_out);
    end
    vectors++;
    for (int i = 0; i < 15; i++) begin
      tick();
      want = (i < 7) ? 2'd2 : 2'd3;
      if (bus.px_valid !== 1'b1 || bus.px_out !== want) begin
        miscompares++;
        $display("FAIL t6_wrap[%0d] valid=%0d out=%0d want 1/%0d", i, bus.px_valid,
                 bus.px_out, want);
      end
      vectors++;
    end
    bus.px_stall = 1'b1;
  endtask

  task automatic test_line_start_priority();
    start_line(3'd0);
    push_bg(8'hFF, 8'h00);
    bus.line_start = 1'b1;
    bus.bg_push    = 1'b1;
    bus.px_stall   = 1'b0;
    tick();
    bus.line_start = 1'b0;
    bus.bg_push    = 1'b0;
    bus.px_stall   = 1'b1;
    if (bus.bg_count !== 5'd0 || bus.px_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ls_prio count=%0d valid=%0d want 0/0", bus.bg_count, bus.px_valid);
    end
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL ls_keeps_ovf got %0d want 1", bus.overflow);
    end
    vectors++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL rst_clears_ovf got %0d want 0", bus.overflow);
    end
    vectors++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_pop();
    test_discard();
    test_sprite_overlay();
    test_obj_priority();
    test_oam_order();
    test_merge_with_pop();
    test_bg_disable();
    test_back_to_back();
    test_line_start_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
